bin_to_rns_9_8_7_serial: RTL and testbench

Sequential forward converter: binary integer -> residue triple for moduli {9, 8, 7}, dynamic range 0..503.
- Produces the residue inputs consumed by the 9/8/7 RNS comparator and other RNS datapath blocks (mod 9 residue 4 bits, mod 8 and mod 7 residues 3 bits each).
- Bit-serial, MSB first, one input bit per cycle.
- Valid/ready handshake on both sides.

---
 rtl/bin_to_rns_9_8_7_serial.sv | 150 +++++++++++++++
 tb/tb_bin_to_rns_9_8_7_serial.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_rns_9_8_7_serial.sv
// bin_to_rns_9_8_7_serial
// Bit-serial forward converter from an unsigned binary operand to the
// residue triple for moduli {9, 8, 7} (dynamic range 0..503). The operand
// is consumed MSB first, one bit per clock, so a conversion takes IN_WIDTH
// cycles after the operand is accepted.
//
// Ports:
//   clk_in         clock, all state on rising edge
//   rst_n_in       synchronous active-low reset
//   bin_in         unsigned binary operand (IN_WIDTH bits)
//   in_valid_in    bin_in valid
//   in_ready_out   converter idle and able to accept an operand
//   r1_out         residue mod 9 (0..8)
//   r2_out         residue mod 8 (0..7)
//   r3_out         residue mod 7 (0..6)
//   out_valid_out  residues valid, held until out_ready_in
//   out_ready_in   consumer accepts residues
//   range_err_out  (only with BIN_TO_RNS_RANGE_CHECK_EN) operand was >= 504
//
// Optional feature macro: BIN_TO_RNS_RANGE_CHECK_EN adds range_err_out.
module bin_to_rns_9_8_7_serial #(
  parameter int unsigned IN_WIDTH = 9
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [IN_WIDTH-1:0] bin_in,
  input  logic                in_valid_in,
  output logic                in_ready_out,
  output logic [3:0]          r1_out,
  output logic [2:0]          r2_out,
  output logic [2:0]          r3_out,
  output logic                out_valid_out,
  input  logic                out_ready_in
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
  ,
  output logic                range_err_out
`endif
);

  localparam int unsigned CNT_W = $clog2(IN_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]    cnt;
  logic [3:0]          a9;
  logic [2:0]          a8;
  logic [2:0]          a7;

  logic                bit_in;
  logic [4:0]          t9;
  logic [3:0]          t7;
  logic [3:0]          a9_nx;
  logic [2:0]          a8_nx;
  logic [2:0]          a7_nx;

`ifdef BIN_TO_RNS_RANGE_CHECK_EN
  logic                op_big;
`endif

  // Horner step: acc <- (2*acc + b) mod m. Since acc < m, 2*acc + b < 2m,
  // so a single conditional subtract keeps the accumulator reduced.
  always_comb begin
    bit_in = shreg[IN_WIDTH-1];
    t9     = {a9, 1'b0} + {4'd0, bit_in};
    t7     = {a7, 1'b0} + {3'd0, bit_in};
    a9_nx  = (t9 >= 5'd9) ? 4'(t9 - 5'd9) : t9[3:0];
    a7_nx  = (t7 >= 4'd7) ? 3'(t7 - 4'd7) : t7[2:0];
    // mod 8 is simply the three most recently shifted-in bits
    a8_nx  = {a8[1:0], bit_in};
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      shreg         <= '0;
      cnt           <= '0;
      a9            <= '0;
      a8            <= '0;
      a7            <= '0;
      r1_out        <= '0;
      r2_out        <= '0;
      r3_out        <= '0;
      in_ready_out  <= 1'b1;
      out_valid_out <= 1'b0;
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
      op_big        <= 1'b0;
      range_err_out <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_in) begin
            shreg        <= bin_in;
            a9           <= '0;
            a8           <= '0;
            a7           <= '0;
            cnt          <= CNT_W'(IN_WIDTH - 1);
            in_ready_out <= 1'b0;
            state        <= BUSY;
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
            op_big       <= (bin_in >= IN_WIDTH'(504));
`endif
          end
        end

        BUSY: begin
          shreg <= {shreg[IN_WIDTH-2:0], 1'b0};
          a9    <= a9_nx;
          a8    <= a8_nx;
          a7    <= a7_nx;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            r1_out        <= a9_nx;
            r2_out        <= a8_nx;
            r3_out        <= a7_nx;
            out_valid_out <= 1'b1;
            state         <= DONE;
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
            range_err_out <= op_big;
`endif
          end
        end

        DONE: begin
          if (out_ready_in) begin
            out_valid_out <= 1'b0;
            in_ready_out  <= 1'b1;
            state         <= IDLE;
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
            range_err_out <= 1'b0;
`endif
          end
        end

        default: begin
          state         <= IDLE;
          in_ready_out  <= 1'b1;
          out_valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_rns_9_8_7_serial.sv
// Self-checking bench for bin_to_rns_9_8_7_serial: a vector table of known
// conversions, hand-written backpressure and mid-operation reset sequences,
// random operands and a full 0..511 sweep against plain x%9, x%8, x%7
// arithmetic, plus a 12-bit instance.
module tb_bin_to_rns_9_8_7_serial;

  logic        clk;
  logic        rst_n;

  logic [8:0]  bin;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  r1;
  logic [2:0]  r2;
  logic [2:0]  r3;
  logic        out_valid;
  logic        out_ready;

  logic [11:0] bin12;
  logic        in_valid12;
  logic        in_ready12;
  logic [3:0]  r1_12;
  logic [2:0]  r2_12;
  logic [2:0]  r3_12;
  logic        out_valid12;
  logic        out_ready12;

`ifdef BIN_TO_RNS_RANGE_CHECK_EN
  logic        rerr;
  logic        rerr12;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bin_to_rns_9_8_7_serial #(.IN_WIDTH(9)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .bin_in        (bin),
    .in_valid_in   (in_valid),
    .in_ready_out  (in_ready),
    .r1_out        (r1),
    .r2_out        (r2),
    .r3_out        (r3),
    .out_valid_out (out_valid),
    .out_ready_in  (out_ready)
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
    ,
    .range_err_out (rerr)
`endif
  );

  bin_to_rns_9_8_7_serial #(.IN_WIDTH(12)) dut12 (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .bin_in        (bin12),
    .in_valid_in   (in_valid12),
    .in_ready_out  (in_ready12),
    .r1_out        (r1_12),
    .r2_out        (r2_12),
    .r3_out        (r3_12),
    .out_valid_out (out_valid12),
    .out_ready_in  (out_ready12)
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
    ,
    .range_err_out (rerr12)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Accumulators must stay reduced in every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      assert (dut.a9 <= 4'd8 && dut.a7 <= 3'd6 && dut12.a9 <= 4'd8 && dut12.a7 <= 3'd6)
      else begin
        n_bad++;
        $display("FAIL acc_range: a9=%0d a7=%0d a9_12=%0d a7_12=%0d required a9<=8 a7<=6",
                 dut.a9, dut.a7, dut12.a9, dut12.a7);
      end
    end
  end

  // Called at a negedge with the 9-bit converter idle. Checks acceptance,
  // latency, residues and (when out_ready is high) the return to IDLE.
  task automatic convert(input int unsigned x, input int e1, input int e2, input int e3);
    int lat;
    check("accept_ready", int'(in_ready), 1);
    bin      = 9'(x);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 9);
    check("r1", int'(r1), e1);
    check("r2", int'(r2), e2);
    check("r3", int'(r3), e3);
    check("busy_not_ready", int'(in_ready), 0);
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
    check("range_err", int'(rerr), (x >= 504) ? 1 : 0);
`endif
    if (out_ready) begin
      @(negedge clk);
      check("idle_ready", int'(in_ready), 1);
      check("idle_valid", int'(out_valid), 0);
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
      check("range_err_clr", int'(rerr), 0);
`endif
    end
  endtask

  typedef struct {
    int unsigned x;
    int          e1;
    int          e2;
    int          e3;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lat;
    bit seen;
    clk         = 1'b0;
    rst_n       = 1'b0;
    bin         = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    bin12       = '0;
    in_valid12  = 1'b0;
    out_ready12 = 1'b1;

    tbl[0] = '{10,  1, 2, 3};
    tbl[1] = '{0,   0, 0, 0};
    tbl[2] = '{503, 8, 7, 6};
    tbl[3] = '{255, 3, 7, 3};
    tbl[4] = '{504, 0, 0, 0};
    tbl[5] = '{511, 7, 7, 0};

    // Reset then idle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", int'(in_ready), 1);
    check("rst_valid", int'(out_valid), 0);
    check("rst_r1", int'(r1), 0);
    check("rst_r2", int'(r2), 0);
    check("rst_r3", int'(r3), 0);
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
    check("rst_err", int'(rerr), 0);
`endif

    // Table-driven conversions
    foreach (tbl[i]) convert(tbl[i].x, tbl[i].e1, tbl[i].e2, tbl[i].e3);

    // Backpressure: results held, new operand ignored
    out_ready = 1'b0;
    convert(10, 1, 2, 3);
    bin      = 9'd503;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      check("bp_ready", int'(in_ready), 0);
      check("bp_r1", int'(r1), 1);
      check("bp_r2", int'(r2), 2);
      check("bp_r3", int'(r3), 3);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_ready", int'(in_ready), 1);
    check("bp_rel_valid", int'(out_valid), 0);
    check("bp_hold_r1", int'(r1), 1);
    check("bp_hold_r3", int'(r3), 3);
    @(negedge clk);
    check("bp_no_accept", int'(in_ready), 1);

    // Reset on the 4th BUSY edge discards the operand
    bin      = 9'd503;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_ready", int'(in_ready), 1);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_r1", int'(r1), 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_result", int'(seen), 0);
    convert(10, 1, 2, 3);

    // Random operands against the reference model
    for (int k = 0; k < 60; k++) begin
      int unsigned x;
      x = $urandom_range(0, 511);
      convert(x, int'(x % 9), int'(x % 8), int'(x % 7));
    end

    // Exhaustive sweep at maximum rate
    for (int unsigned x = 0; x < 512; x++)
      convert(x, int'(x % 9), int'(x % 8), int'(x % 7));

    // 12-bit instance
    check("w12_ready", int'(in_ready12), 1);
    bin12      = 12'd4095;
    in_valid12 = 1'b1;
    @(negedge clk);
    in_valid12 = 1'b0;
    lat = 0;
    while (!out_valid12 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("w12_latency", lat, 12);
    check("w12_r1", int'(r1_12), 0);
    check("w12_r2", int'(r2_12), 7);
    check("w12_r3", int'(r3_12), 0);
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
    check("w12_err", int'(rerr12), 1);
`endif
    @(negedge clk);
    check("w12_idle", int'(in_ready12), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
